// File: rtl/cand_scanner_pkg.sv
// Shared types and widths for the candidate scanner and its bitmap memory.
// Default geometry matches the 14x14 candidate board.
package cand_scanner_pkg;

  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  localparam int DEF_NUM_ELEMENTS = 14;
  localparam int DEF_NUM_ROWS     = 14;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/code_pri.sv
// Leftmost-first priority encoder: column 0 is leftmost and wins.
// active flags any set bit; index is 0 when nothing is set.
module code_pri
  import cand_scanner_pkg::*;
#(
  parameter int num_elements = DEF_NUM_ELEMENTS
) (
  input  logic [num_elements-1:0] code,
  output logic                    active,
  output logic [COL_W-1:0]        leftmost_element
);

  always_comb begin
    active = |code;
    leftmost_element = '0;
    for (int i = num_elements - 1; i >= 0; i--) begin
      if (code[i]) leftmost_element = COL_W'(i);
    end
  end

endmodule

// File: rtl/cand_scanner.sv
// Walks the candidate bitmap row by row and streams each set bit as (row, col).
// Define CAND_SCANNER_COUNT_EN to add the saturating cand_count output.
module cand_scanner
  import cand_scanner_pkg::*;
#(
  parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
  parameter int NUM_ROWS     = DEF_NUM_ROWS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ROW_W-1:0]        rd_addr,
  input  logic [NUM_ELEMENTS-1:0] rd_data,
  output logic                    cand_valid,
  input  logic                    cand_ready,
  output logic [ROW_W-1:0]        cand_row,
  output logic [COL_W-1:0]        cand_col
`ifdef CAND_SCANNER_COUNT_EN
  ,
  output logic [7:0]              cand_count
`endif
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t                  state, state_n;
  logic [ROW_W-1:0]        row, row_n;
  logic [NUM_ELEMENTS-1:0] mask, mask_n;
  logic                    active;
  logic [COL_W-1:0]        col;

  code_pri #(
    .num_elements(NUM_ELEMENTS)
  ) u_pri (
    .code            (mask),
    .active          (active),
    .leftmost_element(col)
  );

  assign rd_addr  = row;
  assign cand_row = row;
  assign cand_col = col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      mask  <= mask_n;
    end
  end

  always_comb begin
    state_n    = state;
    row_n      = row;
    mask_n     = mask;
    rd_en      = 1'b0;
    done       = 1'b0;
    cand_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) begin
          row_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        mask_n  = rd_data;
        state_n = SCAN;
      end
      SCAN: begin
        if (active) begin
          cand_valid = 1'b1;
          if (cand_ready)
            mask_n = mask & ~(NUM_ELEMENTS'(1) << col);
        end else if (row == LAST_ROW) begin
          state_n = DONE;
        end else begin
          row_n   = row + 1'b1;
          state_n = FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef CAND_SCANNER_COUNT_EN
  logic hs;
  assign hs = cand_valid & cand_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cand_count <= '0;
    else if (state == IDLE && start)
      cand_count <= '0;
    else if (hs && cand_count != 8'hFF)
      cand_count <= cand_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cand_scanner.sv
// Bench for cand_scanner: bitmap memory model, candidate queue model,
// per-cycle compare plus directed literal checks.
module tb_cand_scanner;

  localparam int NE = 14;
  localparam int NR = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cand_ready = 1'b1;
  logic          busy, done, rd_en, cand_valid;
  logic [3:0]    rd_addr, cand_row, cand_col;
  logic [NE-1:0] rd_data;
`ifdef CAND_SCANNER_COUNT_EN
  logic [7:0]    cand_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cand_scanner #(
    .NUM_ELEMENTS(NE),
    .NUM_ROWS    (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cand_valid(cand_valid),
    .cand_ready(cand_ready),
    .cand_row  (cand_row),
    .cand_col  (cand_col)
`ifdef CAND_SCANNER_COUNT_EN
    ,
    .cand_count(cand_count)
`endif
  );

  // synchronous bitmap memory, one cycle read latency
  logic [NE-1:0] mem [NR];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int exp_row[$], exp_col[$];
  int acc_row[$], acc_col[$];
  bit in_pass = 0;
  int edges, stalls, rd_next, busy_cnt, k_bits;
  int last_done_edge = -1;
  int mode = 0;
  int hold = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ready patterns: 0 high, 1 toggle, 2 low for hold valid cycles, 3 low
  always @(posedge clk) begin
    #2;
    case (mode)
      0: cand_ready = 1'b1;
      1: cand_ready = ~cand_ready;
      2: begin
        if (cand_valid && hold > 0) begin
          cand_ready = 1'b0;
          hold--;
        end else cand_ready = 1'b1;
      end
      default: cand_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (in_pass) begin
      edges++;
      check("busy", busy, 1);
      busy_cnt++;
      if (rd_en) begin
        check("rd_addr", rd_addr, rd_next);
        rd_next++;
      end
      if (cand_valid) begin
        if (exp_row.size() == 0) begin
          check("spurious_cand", 1, 0);
        end else begin
          check("cand_row", cand_row, exp_row[0]);
          check("cand_col", cand_col, exp_col[0]);
          if (cand_ready) begin
            acc_row.push_back(cand_row);
            acc_col.push_back(cand_col);
            void'(exp_row.pop_front());
            void'(exp_col.pop_front());
          end else stalls++;
        end
      end
      if (done) begin
        last_done_edge = edges;
        check("done_edge", edges, 3*NR + k_bits + stalls);
        check("cands_left", exp_row.size(), 0);
        check("rd_count", rd_next, NR);
        check("busy_cycles", busy_cnt, 3*NR + k_bits + stalls + 1);
`ifdef CAND_SCANNER_COUNT_EN
        check("cand_count", cand_count, k_bits);
`endif
        in_pass = 0;
      end
    end
  end

  task automatic run_pass();
    exp_row.delete(); exp_col.delete();
    acc_row.delete(); acc_col.delete();
    k_bits = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NE; c++)
        if (mem[r][c]) begin
          exp_row.push_back(r);
          exp_col.push_back(c);
          k_bits++;
        end
    stalls = 0; rd_next = 0; busy_cnt = 0;
    last_done_edge = -1;
    @(negedge clk); #1;
    edges = -1; in_pass = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1000 && in_pass; i++) @(negedge clk);
    if (in_pass) begin
      check("done_timeout", 0, 1);
      in_pass = 0;
    end
  endtask

  task automatic check_idle();
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_valid", cand_valid, 0);
    end
  endtask

  int lit_c[3] = '{0, 5, 13};

  initial begin
    for (int r = 0; r < NR; r++) mem[r] = '0;
    rd_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", cand_valid, 0);
    check("rst_row", cand_row, 0);
    check("rst_col", cand_col, 0);
    rst_n = 1'b1;

    // empty board
    run_pass();
    check("t1_done_lit", last_done_edge, 42);
    check_idle();

    // row 3: bits 0, 5, 13
    mem[3] = 14'h2021;
    run_pass();
    check("t2_done_lit", last_done_edge, 45);
    check("t2_n", acc_col.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_row", i < acc_row.size() ? acc_row[i] : -1, 3);
      check("t2_col", i < acc_col.size() ? acc_col[i] : -1, lit_c[i]);
    end
    check_idle();
`ifdef CAND_SCANNER_COUNT_EN
    check("t2_count_hold", cand_count, 3);
`endif

    // stall first candidate for 4 cycles
    mode = 2; hold = 4;
    run_pass();
    check("t3_stalls", stalls, 4);
    check("t3_done_lit", last_done_edge, 49);
    mode = 0;
    check_idle();

    // full row 0, ready toggling
    mem[3] = '0;
    mem[0] = 14'h3FFF;
    mode = 1;
    run_pass();
    check("t4_n", acc_col.size(), 14);
    for (int i = 0; i < 14; i++) begin
      check("t4_row", i < acc_row.size() ? acc_row[i] : -1, 0);
      check("t4_col", i < acc_col.size() ? acc_col[i] : -1, i);
    end
    mode = 0;
    check_idle();

    // start while busy is ignored
    fork
      run_pass();
      begin
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("t5_done_lit", last_done_edge, 42 + 14);
    check_idle();

    // async reset mid-scan
    mode = 3;
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !cand_valid; i++) @(negedge clk);
    check("t6_valid_seen", cand_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", cand_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_rd_en", rd_en, 0);
    check("t6_done", done, 0);
    check("t6_row", cand_row, 0);
    check("t6_col", cand_col, 0);
    check("t6_addr", rd_addr, 0);
`ifdef CAND_SCANNER_COUNT_EN
    check("t6_count", cand_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    check_idle();
    mem[0] = '0;
    mem[5] = 14'h0002;
    run_pass();
    check("t6_done_lit", last_done_edge, 43);
    check("t6_n", acc_col.size(), 1);
    check("t6_cand", acc_col.size() > 0 ? acc_row[0]*16 + acc_col[0] : -1,
          5*16 + 1);
    check_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
